// File: rtl/cla_16bit.sv
// rtl/cla_16bit.sv - 16-bit two-level carry-lookahead adder with registered sum/cout
module cla_16bit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] c;
    logic [3:0]  gp;
    logic [3:0]  gg;
    logic [3:0]  cg;
    logic        c16;
    logic [15:0] sum_d;
    logic [15:0] sum_q;
    logic        cout_d;
    logic        cout_q;

    always_comb begin
        p = a ^ b;
        g = a & b;
    end

    // Per-group propagate/generate summaries feeding the second level.
    always_comb begin
        gp = '0;
        gg = '0;
        for (int k = 0; k < 4; k++) begin
            gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
    end

    // Group carries are flattened so no carry ripples from group to group.
    always_comb begin
        cg[0] = cin;
        cg[1] = gg[0] | (gp[0] & cin);
        cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin);
        c16   = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    end

    always_comb begin
        c = '0;
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = cg[k];
            c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & cg[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
        end
    end

    always_comb begin
        sum_d  = p ^ c;
        cout_d = c16;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= 16'h0000;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_cla_16bit.sv
// tb/tb_cla_16bit.sv - directed and back-to-back checks of cla_16bit
module tb_cla_16bit;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;

    int checks;
    int errors;

    cla_16bit dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        a = 16'hA5C3; b = 16'h7E19; cin = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cout, sum} !== 17'h0_0000) begin
            errors++;
            $display("FAIL reset_immediate got cout=%b sum=%h want cout=0 sum=0000", cout, sum);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({cout, sum} !== 17'h0_0000) begin
            errors++;
            $display("FAIL reset_hold got cout=%b sum=%h want cout=0 sum=0000", cout, sum);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic apply_check(input string name, input logic [15:0] va,
                               input logic [15:0] vb, input logic vc,
                               input logic [15:0] want_sum, input logic want_cout);
        @(negedge clk);
        a = va; b = vb; cin = vc;
        @(posedge clk);
        #1;
        checks++;
        if (sum !== want_sum || cout !== want_cout) begin
            errors++;
            $display("FAIL %s got cout=%b sum=%h want cout=%b sum=%h",
                     name, cout, sum, want_cout, want_sum);
        end
    endtask

    task automatic test_zero();
        apply_check("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_small();
        apply_check("small_1", 16'h001F, 16'h000C, 1'b0, 16'h002B, 1'b0);
        apply_check("small_2", 16'h001F, 16'h000C, 1'b0, 16'h002B, 1'b0);
        @(negedge clk);
        checks++;
        if (sum !== 16'h002B || cout !== 1'b0) begin
            errors++;
            $display("FAIL small_hold got cout=%b sum=%h want cout=0 sum=002b", cout, sum);
        end
    endtask

    task automatic test_mixed();
        apply_check("mixed", 16'hC61F, 16'h018C, 1'b1, 16'hC7AC, 1'b0);
        apply_check("group_carry", 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0);
        apply_check("wrap", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    endtask

    task automatic test_full_prop();
        apply_check("prop_ffff_0_1", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
        apply_check("prop_ffff_ffff_1", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        apply_check("prop_ffff_ffff_0", 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [16:0] want;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            want = {1'b0, a} + {1'b0, b} + {16'b0, cin};
            @(posedge clk);
            #1;
            checks++;
            if ({cout, sum} !== want) begin
                errors++;
                $display("FAIL b2b_%0d got %h want %h", i, {cout, sum}, want);
            end
            if (i == 20) begin
                #2 rst = 1'b1;
                #1;
                checks++;
                if ({cout, sum} !== 17'h0_0000) begin
                    errors++;
                    $display("FAIL midrun_reset got %h want 00000", {cout, sum});
                end
                @(negedge clk);
                a = 16'h1234; b = 16'h4321; cin = 1'b1;
                @(posedge clk);
                #1;
                checks++;
                if ({cout, sum} !== 17'h0_0000) begin
                    errors++;
                    $display("FAIL midrun_reset_hold got %h want 00000", {cout, sum});
                end
                @(negedge clk);
                rst = 1'b0;
                a = 16'hF00F; b = 16'h1FF1; cin = 1'b0;
                @(posedge clk);
                #1;
                checks++;
                if ({cout, sum} !== 17'h1_1000) begin
                    errors++;
                    $display("FAIL after_release got %h want 11000", {cout, sum});
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        test_reset();
        test_zero();
        test_small();
        test_mixed();
        test_full_prop();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
